// File: rtl/dfi_phy_responder.sv
// DFI PHY responder: decodes controller DFI commands, tracks open banks, keeps write
// data in a small backing array and returns read beats at a fixed PHY read latency.
module dfi_phy_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int BANK_WIDTH  = 3,
  parameter int DATA_WIDTH  = 64,
  parameter int COL_BITS    = 5,
  parameter int INIT_CYCLES = 16,
  parameter int TPHY_RDLAT  = 4,
  parameter int QDEPTH      = 4
) (
  input  logic                    core_clk,
  input  logic                    core_aresetn,
  input  logic                    dfi_init_start,
  output logic                    dfi_init_complete,
  input  logic                    dfi_cs_n,
  input  logic                    dfi_ras_n,
  input  logic                    dfi_cas_n,
  input  logic                    dfi_we_n,
  input  logic [BANK_WIDTH-1:0]   dfi_bank,
  input  logic [ADDR_WIDTH-1:0]   dfi_address,
  input  logic                    dfi_wrdata_en,
  input  logic [DATA_WIDTH-1:0]   dfi_wrdata,
  input  logic [DATA_WIDTH/8-1:0] dfi_wrdata_mask,
  input  logic                    dfi_rddata_en,
  output logic [DATA_WIDTH-1:0]   dfi_rddata,
  output logic                    dfi_rddata_valid,
  output logic [4:0]              err
);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int IDX_W  = BANK_WIDTH + COL_BITS;
  localparam int NBANK  = 1 << BANK_WIDTH;
  localparam int NIDX   = 1 << IDX_W;
  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W  = $clog2(INIT_CYCLES + 1);
  localparam int LAST   = TPHY_RDLAT - 1;
  localparam int PREV   = (TPHY_RDLAT > 1) ? TPHY_RDLAT - 2 : 0;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic [1:0] {ST_WAIT, ST_INIT, ST_READY} state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 init_cnt;
  logic [NBANK-1:0]                 bank_open;
  logic [NBANK-1:0][ADDR_WIDTH-1:0] bank_row;
  logic [DATA_WIDTH-1:0]            mem [NIDX];
  logic [IDX_W-1:0]                 rd_q [QDEPTH];
  logic [IDX_W-1:0]                 wr_q [QDEPTH];
  logic [PTR_W-1:0]                 rd_head, rd_tail, wr_head, wr_tail;
  logic [PTR_W:0]                   rd_count, wr_count;
  logic [TPHY_RDLAT-1:0]            pipe_v;
  logic [DATA_WIDTH-1:0]            pipe_d [TPHY_RDLAT];

  logic [2:0]            cmd;
  logic                  ready, cmd_any, cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref;
  logic                  bank_is_open;
  logic [IDX_W-1:0]      idx, rd_idx, wr_idx;
  logic                  rd_pop, wr_pop, rd_full, wr_full;
  logic                  rd_ok, wr_ok, rd_push, wr_push;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  last_v;
  logic [DATA_WIDTH-1:0] last_d;
  logic [4:0]            err_set;
  logic                  unused_bits;

  assign cmd          = {dfi_ras_n, dfi_cas_n, dfi_we_n};
  assign ready        = (state == ST_READY);
  assign cmd_any      = !dfi_cs_n && (cmd != CMD_NOP);
  assign cmd_act      = !dfi_cs_n && (cmd == CMD_ACT);
  assign cmd_rd       = !dfi_cs_n && (cmd == CMD_RD);
  assign cmd_wr       = !dfi_cs_n && (cmd == CMD_WR);
  assign cmd_pre      = !dfi_cs_n && (cmd == CMD_PRE);
  assign cmd_ref      = !dfi_cs_n && (cmd == CMD_REF);
  assign bank_is_open = bank_open[dfi_bank];
  assign idx          = {dfi_bank, dfi_address[COL_BITS-1:0]};

  assign rd_idx  = rd_q[rd_head];
  assign wr_idx  = wr_q[wr_head];
  assign rd_pop  = dfi_rddata_en && (rd_count != '0);
  assign wr_pop  = dfi_wrdata_en && (wr_count != '0);
  assign rd_full = (rd_count == (PTR_W+1)'(QDEPTH));
  assign wr_full = (wr_count == (PTR_W+1)'(QDEPTH));
  assign rd_ok   = ready && cmd_rd && bank_is_open;
  assign wr_ok   = ready && cmd_wr && bank_is_open;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign rd_push = rd_ok && (!rd_full || rd_pop);
  assign wr_push = wr_ok && (!wr_full || wr_pop);

  assign err_set[0] = cmd_any && !ready;
  assign err_set[1] = ready && ((cmd_act && bank_is_open) || (cmd_ref && |bank_open) ||
                                ((cmd_rd || cmd_wr) && !bank_is_open));
  assign err_set[2] = (rd_ok && !rd_push) || (wr_ok && !wr_push);
  assign err_set[3] = dfi_wrdata_en && !wr_pop;
  assign err_set[4] = dfi_rddata_en && !rd_pop;

  // Read is write-first: a same-cycle write beat to the same index is merged in.
  always_comb begin
    rd_word = '0;
    if (rd_pop) begin
      rd_word = mem[rd_idx];
      if (wr_pop && (wr_idx == rd_idx)) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (!dfi_wrdata_mask[b]) rd_word[b*8 +: 8] = dfi_wrdata[b*8 +: 8];
        end
      end
    end
  end

  assign last_v           = (TPHY_RDLAT == 1) ? dfi_rddata_en : pipe_v[PREV];
  assign last_d           = (TPHY_RDLAT == 1) ? rd_word : pipe_d[PREV];
  assign dfi_rddata_valid = pipe_v[LAST];
  assign unused_bits      = ^{dfi_address, bank_row, pipe_d[LAST]};

  always_ff @(posedge core_clk) begin
    if (wr_pop) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!dfi_wrdata_mask[b]) mem[wr_idx][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
      end
    end
    if (rd_push) rd_q[rd_tail] <= idx;
    if (wr_push) wr_q[wr_tail] <= idx;
  end

  always_ff @(posedge core_clk or negedge core_aresetn) begin
    if (!core_aresetn) begin
      state             <= ST_WAIT;
      init_cnt          <= '0;
      dfi_init_complete <= 1'b0;
      bank_open         <= '0;
      bank_row          <= '0;
      rd_head           <= '0;
      rd_tail           <= '0;
      rd_count          <= '0;
      wr_head           <= '0;
      wr_tail           <= '0;
      wr_count          <= '0;
      pipe_v            <= '0;
      for (int i = 0; i < TPHY_RDLAT; i++) pipe_d[i] <= '0;
      dfi_rddata        <= '0;
      err               <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (dfi_init_start) begin
            if (INIT_CYCLES <= 1) begin
              state             <= ST_READY;
              dfi_init_complete <= 1'b1;
            end else begin
              state    <= ST_INIT;
              init_cnt <= CNT_W'(1);
            end
          end
        end
        ST_INIT: begin
          if (init_cnt >= CNT_W'(INIT_CYCLES - 1)) begin
            state             <= ST_READY;
            dfi_init_complete <= 1'b1;
          end else begin
            init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        ST_READY: state <= ST_READY;
        default:  state <= ST_WAIT;
      endcase

      if (ready && cmd_act) begin
        bank_open[dfi_bank] <= 1'b1;
        bank_row[dfi_bank]  <= dfi_address;
      end else if (ready && cmd_pre) begin
        if (dfi_address[10]) bank_open <= '0;
        else                 bank_open[dfi_bank] <= 1'b0;
      end

      if (rd_pop)  rd_head <= rd_head + PTR_W'(1);
      if (rd_push) rd_tail <= rd_tail + PTR_W'(1);
      if (rd_push && !rd_pop)      rd_count <= rd_count + (PTR_W+1)'(1);
      else if (rd_pop && !rd_push) rd_count <= rd_count - (PTR_W+1)'(1);

      if (wr_pop)  wr_head <= wr_head + PTR_W'(1);
      if (wr_push) wr_tail <= wr_tail + PTR_W'(1);
      if (wr_push && !wr_pop)      wr_count <= wr_count + (PTR_W+1)'(1);
      else if (wr_pop && !wr_push) wr_count <= wr_count - (PTR_W+1)'(1);

      pipe_v[0] <= dfi_rddata_en;
      pipe_d[0] <= rd_word;
      for (int i = 1; i < TPHY_RDLAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      if (last_v) dfi_rddata <= last_d;

      err <= err | err_set;
    end
  end
endmodule

// File: doc/dfi_phy_responder.md
Name: dfi_phy_responder

Overview:
- Behavioural-synthesisable DFI PHY responder: the far end of the memory controller's DFI master port (m_dfi).
- Decodes DFI commands, tracks per-bank open rows, stores write data in a small backing array and returns read data at the fixed PHY read latency.
- Drives dfi_init_complete and flags protocol violations in a sticky error vector.
- Used in the controller test top in place of a real PHY/DRAM, sharing core_clk.

Parameters:
ADDR_WIDTH, 14, DFI row/column address width
BANK_WIDTH, 3, DFI bank address width
DATA_WIDTH, 64, DFI data bus width (mask width = DATA_WIDTH/8)
COL_BITS, 5, low column bits used to index the backing array
INIT_CYCLES, 16, cycles from init start to dfi_init_complete
TPHY_RDLAT, 4, cycles from dfi_rddata_en to dfi_rddata_valid (>=1)
QDEPTH, 4, depth of read-command and write-command queues (power of 2)

Ports:
core_clk  in  1  clock
core_aresetn  in  1  asynchronous active-low reset
dfi_init_start  in  1  controller requests PHY initialisation
dfi_init_complete  out  1  PHY ready
dfi_cs_n  in  1  chip select, active low
dfi_ras_n  in  1  row strobe
dfi_cas_n  in  1  column strobe
dfi_we_n  in  1  write enable
dfi_bank  in  BANK_WIDTH  bank address
dfi_address  in  ADDR_WIDTH  row/column address; bit 10 = precharge-all
dfi_wrdata_en  in  1  write data beat valid
dfi_wrdata  in  DATA_WIDTH  write data
dfi_wrdata_mask  in  DATA_WIDTH/8  byte mask, 1 = byte not written
dfi_rddata_en  in  1  read data beat requested
dfi_rddata  out  DATA_WIDTH  read data
dfi_rddata_valid  out  1  read data valid
err  out  5  sticky protocol error flags

Behaviour:
- Reset (async assert, sync release): dfi_init_complete=0, dfi_rddata=0, dfi_rddata_valid=0, err=0, all banks closed, queues empty, read pipeline empty, FSM=WAIT. Backing array (2^(BANK_WIDTH+COL_BITS) words) is NOT reset; bench must write before reading.
- Init FSM: WAIT -> INIT on dfi_init_start=1; INIT counts INIT_CYCLES cycles, then READY with dfi_init_complete=1 registered (first high exactly INIT_CYCLES cycles after the start cycle). READY is held until reset; dfi_init_start ignored outside WAIT.
- Command decode only when dfi_cs_n=0, {ras_n,cas_n,we_n}: 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 111 NOP. cs_n=1 = NOP.
- Any non-NOP command while not READY: err[0]=1, command ignored.
- ACT: opens bank, records row; ACT to an already-open bank: err[1]=1, row updated.
- PRE: closes dfi_bank, or all banks if dfi_address[10]=1; PRE to a closed bank is legal.
- REF with any bank open: err[1]=1. MRS: no effect.
- RD/WR to a closed bank: err[1]=1, command dropped. Otherwise index {dfi_bank, dfi_address[COL_BITS-1:0]} is pushed to the read or write queue; rows alias in the array.
- Push to a full queue: err[2]=1, command dropped. Simultaneous pop and push when full is legal (no error, count unchanged).
- dfi_wrdata_en=1: pop write-queue index; write unmasked bytes of dfi_wrdata that cycle. Write queue empty: err[3]=1, beat discarded (no same-cycle bypass of a WR pushed in that cycle).
- dfi_rddata_en=1: pop read-queue index; read array that cycle, write-first if a same-cycle write targets the same index. Read queue empty: err[4]=1 and a beat of zeros is still returned.
- Read pipeline: TPHY_RDLAT-stage shift register; dfi_rddata_valid high exactly TPHY_RDLAT cycles after each dfi_rddata_en cycle, back-to-back beats preserved; dfi_rddata holds its last value when valid=0.
- err bits set-only until reset. Mid-operation reset flushes queues and pipeline, drops valid immediately, returns FSM to WAIT.

Test Plan:
- Reset, pulse dfi_init_start at cycle 5 -> dfi_init_complete rises at cycle 21 (INIT_CYCLES=16), err=0.
- ACT bank2 row 0x12; WR col 3; wrdata_en with 0xDEADBEEF_01234567, mask 0x00; RD col 3; rddata_en at cycle T -> dfi_rddata_valid at T+4 with 0xDEADBEEF_01234567.
- Write 0xFFFF..FF, then second write 0x0 with mask 0x0F -> read returns 0x00000000_FFFFFFFF.
- Four RDs then four consecutive rddata_en cycles -> four consecutive valid beats, correct order; fifth RD with queue full and no pop -> err[2]=1.
- RD to a closed bank -> err[1]=1; rddata_en with empty queue -> err[4]=1 and a zero beat after 4 cycles; ACT before init complete -> err[0]=1.
- Assert core_aresetn=0 with two beats in flight -> dfi_rddata_valid=0 immediately, no beats after release, dfi_init_complete=0, err=0.
